// File: rtl/ram_dma.sv
// Copy/fill DMA sharing a 16-bit distributed RAM with CPU pass-through and a starvation bound.
// Define DMA_FILL_EN to build the fill operation; otherwise fill commands complete as len=0.
module ram_dma #(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic [WIDTH-1:0] cpu_rd_addr,
  output logic [15:0]      cpu_rd_data,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_wr_addr,
  input  logic [15:0]      cpu_wr_data,
  output logic             cpu_stall,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_src,
  input  logic [WIDTH-1:0] cmd_dst,
  input  logic [WIDTH:0]   cmd_len,
  input  logic [15:0]      cmd_fill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mem_dout_addr,
  input  logic [15:0]      mem_dout,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_din_addr,
  output logic [15:0]      mem_din
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic             is_fill, start_skip, run, conflict, at_limit, grant, forced;
  logic [15:0]      fill_word;

`ifdef DMA_FILL_EN
  logic        op_q;
  logic [15:0] fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 1'b0;
      fill_q <= '0;
    end else if (cmd_ready && cmd_valid) begin
      op_q   <= cmd_op;
      fill_q <= cmd_fill;
    end
  end

  assign is_fill    = op_q;
  assign fill_word  = fill_q;
  assign start_skip = (cmd_len == '0);
`else
  logic unused_fill;
  assign unused_fill = ^cmd_fill;
  assign is_fill     = 1'b0;
  assign fill_word   = '0;
  // Without fill support an op=1 command retires immediately, like len=0.
  assign start_skip  = (cmd_len == '0) | cmd_op;
`endif

  assign run      = (state_q == StRun);
  // Fill leaves the read port to the CPU, so only CPU writes collide with it.
  assign conflict = cpu_we | (cpu_re & ~is_fill);
  assign at_limit = (starve_q == CW'(STARVE_LIMIT));
  assign grant    = run & (~conflict | at_limit);
  assign forced   = run & conflict & at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    starve_d = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          state_d = start_skip ? StDone : StRun;
        end
      end
      StRun: begin
        if (grant) begin
          src_d = src_q + 1'b1;
          dst_d = dst_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (WIDTH + 1)'(1)) state_d = StDone;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == StIdle) & ~rst;
    busy          = (state_q != StIdle) & ~rst;
    done          = (state_q == StDone) & ~rst;
    cpu_stall     = 1'b0;
    cpu_rd_data   = mem_dout;
    mem_dout_addr = cpu_rd_addr;
    mem_we        = cpu_we & ~rst;
    mem_din_addr  = cpu_wr_addr;
    mem_din       = cpu_wr_data;
    if (grant && !rst) begin
      cpu_stall    = forced;
      mem_we       = 1'b1;
      mem_din_addr = dst_q;
      mem_din      = is_fill ? fill_word : mem_dout;
      if (!is_fill) mem_dout_addr = src_q;
    end
  end
endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: behavioural RAM plus per-scenario tasks with inline checks.
module tb_ram_dma;
  localparam int unsigned W  = 13;
  localparam int unsigned SL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_re = 1'b0, cpu_we = 1'b0;
  logic [W-1:0]  cpu_rd_addr = '0, cpu_wr_addr = '0;
  logic [15:0]   cpu_rd_data, cpu_wr_data = '0;
  logic          cpu_stall;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [W-1:0]  cmd_src = '0, cmd_dst = '0;
  logic [W:0]    cmd_len = '0;
  logic [15:0]   cmd_fill = '0;
  logic          busy, done;
  logic [W-1:0]  mem_dout_addr, mem_din_addr;
  logic [15:0]   mem_dout, mem_din;
  logic          mem_we;

  int total = 0;
  int bad   = 0;

  ram_dma #(.WIDTH(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
    .cpu_we(cpu_we), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_stall(cpu_stall),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .busy(busy), .done(done),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 7 + 'h1234);
  endfunction

  logic [15:0] ram [0:(1 << W) - 1];
  logic        ram_loaded = 1'b0;
  assign mem_dout = ram[mem_dout_addr];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << W); i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_din_addr] <= mem_din;
    end
  end

  // Called at a negedge with cmd_ready high; returns #1 after the accepting edge.
  task automatic issue(input logic op, input logic [W-1:0] src, input logic [W-1:0] dst,
                       input logic [W:0] len, input logic [15:0] fill);
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    cpu_we      = 1'b1;
    cpu_wr_addr = 'h050;
    cpu_wr_data = 'hDEAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    @(posedge clk);
    #1;
    total++; if (ram['h050] !== init_val('h050)) begin
      bad++; $display("FAIL rst_cpu_write: got %h want %h", ram['h050], init_val('h050));
    end
    rst    = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_copy();
    logic eb, ed, er;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL copy_ready0: got %b want 1", cmd_ready); end
    issue(1'b0, 'h010, 'h100, 4, '0);
    for (int k = 1; k <= 6; k++) begin
      eb = (k <= 5);
      ed = (k == 5);
      er = (k == 6);
      @(negedge clk);
      total++; if (busy !== eb) begin bad++; $display("FAIL copy_busy c%0d: got %b want %b", k, busy, eb); end
      total++; if (done !== ed) begin bad++; $display("FAIL copy_done c%0d: got %b want %b", k, done, ed); end
      total++; if (cmd_ready !== er) begin bad++; $display("FAIL copy_ready c%0d: got %b want %b", k, cmd_ready, er); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL copy_stall c%0d: got %b want 0", k, cpu_stall); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (ram['h100 + i] !== init_val('h010 + i)) begin
        bad++; $display("FAIL copy_data %0d: got %h want %h", i, ram['h100 + i], init_val('h010 + i));
      end
    end
    total++; if (ram['h104] !== init_val('h104)) begin
      bad++; $display("FAIL copy_overrun: got %h want %h", ram['h104], init_val('h104));
    end
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    logic ed;
    logic [W-1:0] dsts [4];
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready0: got %b want 1", cmd_ready); end
    issue(1'b1, '0, 'h1FFE, 4, 'hBEEF);
    cpu_re      = 1'b1;
    cpu_rd_addr = 'h020;
    for (int k = 1; k <= 5; k++) begin
      ed = (k == 5);
      @(negedge clk);
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL fill_stall c%0d: got %b want 0", k, cpu_stall); end
      total++; if (cpu_rd_data !== init_val('h020 + k - 1)) begin
        bad++; $display("FAIL fill_rd c%0d: got %h want %h", k, cpu_rd_data, init_val('h020 + k - 1));
      end
      total++; if (done !== ed) begin bad++; $display("FAIL fill_done c%0d: got %b want %b", k, done, ed); end
      @(posedge clk);
      #1 cpu_rd_addr = cpu_rd_addr + 1'b1;
    end
    cpu_re = 1'b0;
    dsts[0] = 'h1FFE; dsts[1] = 'h1FFF; dsts[2] = 'h0000; dsts[3] = 'h0001;
    for (int i = 0; i < 4; i++) begin
      total++; if (ram[dsts[i]] !== 16'hBEEF) begin
        bad++; $display("FAIL fill_data %h: got %h want beef", dsts[i], ram[dsts[i]]);
      end
    end
    total++; if (ram['h0002] !== init_val('h0002)) begin
      bad++; $display("FAIL fill_overrun: got %h want %h", ram['h0002], init_val('h0002));
    end
  endtask
`else
  task automatic test_fill_off();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL filloff_ready0: got %b want 1", cmd_ready); end
    issue(1'b1, '0, 'h300, 5, 'hBEEF);
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL filloff_done: got %b want 1", done); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL filloff_we: got %b want 0", mem_we); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL filloff_done2: got %b want 0", done); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL filloff_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      total++; if (ram['h300 + i] !== init_val('h300 + i)) begin
        bad++; $display("FAIL filloff_data %0d: got %h want %h", i, ram['h300 + i], init_val('h300 + i));
      end
    end
  endtask
`endif

  task automatic test_len0();
    logic ed;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL len0_ready0: got %b want 1", cmd_ready); end
    issue(1'b0, 'h010, 'h700, 0, '0);
    for (int k = 1; k <= 2; k++) begin
      ed = (k == 1);
      @(negedge clk);
      total++; if (done !== ed) begin bad++; $display("FAIL len0_done c%0d: got %b want %b", k, done, ed); end
      total++; if (busy !== ed) begin bad++; $display("FAIL len0_busy c%0d: got %b want %b", k, busy, ed); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL len0_we c%0d: got %b want 0", k, mem_we); end
    end
    total++; if (ram['h700] !== init_val('h700)) begin
      bad++; $display("FAIL len0_data: got %h want %h", ram['h700], init_val('h700));
    end
  endtask

  task automatic test_starve();
    logic es, ed, stalled;
    int   w;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL starve_ready0: got %b want 1", cmd_ready); end
    issue(1'b0, 'h200, 'h400, 2, '0);
    w           = 0;
    cpu_we      = 1'b1;
    cpu_wr_addr = 'h600;
    cpu_wr_data = 'hC000;
    for (int k = 1; k <= 19; k++) begin
      es = (k == 9) || (k == 18);
      ed = (k == 19);
      @(negedge clk);
      total++; if (cpu_stall !== es) begin bad++; $display("FAIL starve_stall c%0d: got %b want %b", k, cpu_stall, es); end
      total++; if (done !== ed) begin bad++; $display("FAIL starve_done c%0d: got %b want %b", k, done, ed); end
      stalled = cpu_stall;
      @(posedge clk);
      #1;
      if (!stalled) w++;
      cpu_wr_addr = W'('h600 + w);
      cpu_wr_data = 16'('hC000 + w);
    end
    cpu_we = 1'b0;
    for (int i = 0; i < 17; i++) begin
      total++; if (ram['h600 + i] !== 16'('hC000 + i)) begin
        bad++; $display("FAIL starve_cpu %0d: got %h want %h", i, ram['h600 + i], 16'('hC000 + i));
      end
    end
    total++; if (ram['h611] !== init_val('h611)) begin
      bad++; $display("FAIL starve_cpu_extra: got %h want %h", ram['h611], init_val('h611));
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (ram['h400 + i] !== init_val('h200 + i)) begin
        bad++; $display("FAIL starve_copy %0d: got %h want %h", i, ram['h400 + i], init_val('h200 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready0: got %b want 1", cmd_ready); end
    issue(1'b0, 'h010, 'h800, 10, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we: got %b want 0", mem_we); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_rst: got %b want 0", cmd_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy c%0d: got %b want 0", k, busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done c%0d: got %b want 0", k, done); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready c%0d: got %b want 1", k, cmd_ready); end
    end
    for (int i = 0; i < 10; i++) begin
      logic [15:0] exp;
      exp = (i < 3) ? init_val('h010 + i) : init_val('h800 + i);
      total++; if (ram['h800 + i] !== exp) begin
        bad++; $display("FAIL rmid_data %0d: got %h want %h", i, ram['h800 + i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
`ifdef DMA_FILL_EN
    test_fill();
`else
    test_fill_off();
`endif
    test_len0();
    test_starve();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
